// File: rtl/prio_grant_arbiter.sv
// Registered N-input priority arbiter with optional round-robin fairness.
// A winner is sampled in IDLE and held in HOLD until the consumer accepts it.
module prio_grant_arbiter #(
  parameter int N  = 8,
  parameter int RR = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N-1:0]           req,
  output logic                   grant_valid,
  input  logic                   grant_ready,
  output logic [$clog2(N)-1:0]   grant_idx,
  output logic [N-1:0]           grant_onehot,
  output logic                   none
);

  localparam int W = $clog2(N);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic           valid_q, valid_d;
  logic [W-1:0]   idx_q, idx_d;
  logic [N-1:0]   onehot_q, onehot_d;
  logic           none_q, none_d;
  logic [W-1:0]   last_q, last_d;
  logic [W-1:0]   winner_s;

  // Descending search from the start index, wrapping 0 -> N-1 explicitly so
  // non-power-of-two N never yields an index >= N.
  function automatic logic [W-1:0] pick_winner(input logic [N-1:0] r,
                                                input logic [W-1:0] lst);
    int             start;
    int             pos;
    logic           found;
    logic [W-1:0]   pick;
    pick  = '0;
    found = 1'b0;
    if ((RR != 0) && (lst != '0)) begin
      start = int'(lst) - 1;
    end else begin
      start = N - 1;
    end
    for (int k = 0; k < N; k++) begin
      pos = start - k;
      if (pos < 0) begin
        pos = pos + N;
      end else begin
        pos = pos;
      end
      if (!found && r[pos]) begin
        found = 1'b1;
        pick  = pos[W-1:0];
      end else begin
        found = found;
      end
    end
    return pick;
  endfunction

  function automatic logic [N-1:0] to_onehot(input logic [W-1:0] idx);
    logic [N-1:0] one;
    one = {{(N-1){1'b0}}, 1'b1};
    return one << idx;
  endfunction

  assign winner_s = pick_winner(req, last_q);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req != '0) begin
          state_d = ST_HOLD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (grant_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output/datapath next values; last only advances on an accepted grant.
  always_comb begin
    valid_d  = valid_q;
    idx_d    = idx_q;
    onehot_d = onehot_q;
    none_d   = none_q;
    last_d   = last_q;
    case (state_q)
      ST_IDLE: begin
        if (req != '0) begin
          idx_d    = winner_s;
          onehot_d = to_onehot(winner_s);
          valid_d  = 1'b1;
          none_d   = 1'b0;
        end else begin
          valid_d  = 1'b0;
          onehot_d = '0;
          none_d   = 1'b1;
        end
      end
      ST_HOLD: begin
        if (grant_ready) begin
          valid_d  = 1'b0;
          onehot_d = '0;
          last_d   = idx_q;
        end else begin
          valid_d  = 1'b1;
        end
      end
      default: begin
        valid_d  = 1'b0;
        onehot_d = '0;
      end
    endcase
  end

  // Output registers; reset wins over a coincident handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= 1'b0;
      idx_q    <= '0;
      onehot_q <= '0;
      none_q   <= 1'b0;
      last_q   <= '0;
    end else begin
      valid_q  <= valid_d;
      idx_q    <= idx_d;
      onehot_q <= onehot_d;
      none_q   <= none_d;
      last_q   <= last_d;
    end
  end

  assign grant_valid  = valid_q;
  assign grant_idx    = idx_q;
  assign grant_onehot = onehot_q;
  assign none         = none_q;

endmodule

// File: tb/tb_prio_grant_arbiter.sv
// Randomised + directed bench for three arbiter configurations against a
// spec-level reference model.
module tb_prio_grant_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [7:0] req_a, req_b;
  logic [4:0] req_c;
  logic       rdy_a, rdy_b, rdy_c;
  logic       gv_a, gv_b, gv_c, none_a, none_b, none_c;
  logic [2:0] gi_a, gi_b, gi_c;
  logic [7:0] goh_a, goh_b;
  logic [4:0] goh_c;

  prio_grant_arbiter #(.N(8), .RR(0)) u_fix (
    .clk(clk), .reset(reset), .req(req_a), .grant_valid(gv_a),
    .grant_ready(rdy_a), .grant_idx(gi_a), .grant_onehot(goh_a), .none(none_a));
  prio_grant_arbiter #(.N(8), .RR(1)) u_rr8 (
    .clk(clk), .reset(reset), .req(req_b), .grant_valid(gv_b),
    .grant_ready(rdy_b), .grant_idx(gi_b), .grant_onehot(goh_b), .none(none_b));
  prio_grant_arbiter #(.N(5), .RR(1)) u_rr5 (
    .clk(clk), .reset(reset), .req(req_c), .grant_valid(gv_c),
    .grant_ready(rdy_c), .grant_idx(gi_c), .grant_onehot(goh_c), .none(none_c));

  int n_vec = 0;
  int n_err = 0;

  // Reference state per configuration: 0 = fixed N8, 1 = RR N8, 2 = RR N5.
  int   nn[3]  = '{8, 8, 5};
  int   rrm[3] = '{0, 1, 1};
  bit   mv[3];
  bit   mn[3];
  int   mi[3];
  int   ml[3];
  int   moh[3];

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_winner(input logic [7:0] r, input int n, input int rr, input int lst);
    int start;
    int pos;
    start = (rr != 0) ? (lst + n - 1) % n : n - 1;
    for (int k = 0; k < n; k++) begin
      pos = (start - k + n) % n;
      if (r[pos]) return pos;
    end
    return -1;
  endfunction

  task automatic model_step(input int d, input logic [7:0] r, input logic rdy);
    int w;
    if (reset) begin
      mv[d] = 0; mn[d] = 0; mi[d] = 0; ml[d] = 0; moh[d] = 0;
    end else if (!mv[d]) begin
      if (r != 8'h00) begin
        w = ref_winner(r, nn[d], rrm[d], ml[d]);
        mi[d] = w; moh[d] = 1 << w; mv[d] = 1; mn[d] = 0;
      end else begin
        mn[d] = 1;
      end
    end else if (rdy) begin
      mv[d] = 0; moh[d] = 0; ml[d] = mi[d];
    end
  endtask

  task automatic check_all(input int d);
    int v, i, oh, nz;
    case (d)
      0: begin v = gv_a; i = gi_a; oh = goh_a; nz = none_a; end
      1: begin v = gv_b; i = gi_b; oh = goh_b; nz = none_b; end
      default: begin v = gv_c; i = gi_c; oh = goh_c; nz = none_c; end
    endcase
    check_eq($sformatf("d%0d.valid", d), v, mv[d]);
    check_eq($sformatf("d%0d.onehot", d), oh, moh[d]);
    check_eq($sformatf("d%0d.none", d), nz, mn[d]);
    if (mv[d]) check_eq($sformatf("d%0d.idx", d), i, mi[d]);
  endtask

  task automatic step();
    @(posedge clk);
    model_step(0, req_a, rdy_a);
    model_step(1, req_b, rdy_b);
    model_step(2, {3'b000, req_c}, rdy_c);
    #1;
    for (int d = 0; d < 3; d++) check_all(d);
  endtask

  initial begin
    reset = 1'b1;
    req_a = 8'h00; req_b = 8'h00; req_c = 5'h00;
    rdy_a = 1'b0;  rdy_b = 1'b0;  rdy_c = 1'b0;
    step();
    step();
    check_eq("rst_valid", {gv_a, gv_b, gv_c}, 0);
    check_eq("rst_none", {none_a, none_b, none_c}, 0);
    check_eq("rst_idx", {gi_a, gi_b, gi_c}, 0);
    check_eq("rst_onehot", {goh_a, goh_b, goh_c}, 0);

    // Fixed priority, full round-robin sweep and N=5 wrap, run side by side.
    reset = 1'b0;
    req_a = 8'b0010_0110; rdy_a = 1'b1;
    req_b = 8'hFF;        rdy_b = 1'b1;
    req_c = 5'b10001;     rdy_c = 1'b1;
    for (int c = 0; c < 18; c++) begin
      step();
      if (c % 2 == 0) begin
        check_eq("fix_idx", gi_a, 5);
        check_eq("fix_onehot", goh_a, 8'h20);
        check_eq("rr8_seq", gi_b, (7 - c / 2 + 8) % 8);
        check_eq("rr5_seq", gi_c, ((c / 2) % 2 == 0) ? 4 : 0);
      end else begin
        check_eq("rr8_gap", gv_b, 0);
      end
    end

    // Back-pressure on RR8; empty request vector on fixed.
    req_b = 8'h08; rdy_b = 1'b0;
    req_a = 8'h00; req_c = 5'h00;
    step();
    check_eq("bp_idx3", gi_b, 3);
    check_eq("empty_none", none_a, 1);
    check_eq("empty_valid", gv_a, 0);
    req_b = 8'h80; req_a = 8'h01;
    for (int c = 0; c < 5; c++) begin
      step();
      if (c == 0) begin
        check_eq("one_idx0", gi_a, 0);
        check_eq("one_none", none_a, 0);
      end
      check_eq("bp_hold_idx", gi_b, 3);
      check_eq("bp_hold_valid", gv_b, 1);
    end
    rdy_b = 1'b1;
    step();
    check_eq("bp_release", gv_b, 0);
    step();
    check_eq("bp_next_idx7", gi_b, 7);
    check_eq("bp_next_valid", gv_b, 1);

    // Reset during HOLD with a coincident handshake: last must return to 0.
    reset = 1'b1;
    step();
    check_eq("midrst_valid", gv_b, 0);
    reset = 1'b0; req_b = 8'h81; rdy_b = 1'b0;
    step();
    check_eq("midrst_idx7", gi_b, 7);

    // Randomised phase.
    for (int c = 0; c < 600; c++) begin
      reset = ($urandom_range(63) == 0);
      req_a = ($urandom_range(5) == 0) ? 8'h00 : 8'($urandom);
      req_b = ($urandom_range(5) == 0) ? 8'h00 : 8'($urandom);
      req_c = 5'($urandom_range(31));
      rdy_a = ($urandom_range(3) != 0);
      rdy_b = ($urandom_range(3) != 0);
      rdy_c = ($urandom_range(2) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
